mrv1_operand_stage: RTL and testbench
=====================================

MRV1_OPERAND_STAGE -- requirements
Module: mrv1_operand_stage

Interface
REQ-001 SHALL have parameter PC_WIDTH_P, default 32, instruction PC width.
REQ-002 SHALL have parameter DATA_WIDTH_P, default 32, operand and immediate width.
REQ-003 SHALL have parameter REG_ADDR_WIDTH_P, default 5, register index width.
REQ-004 SHALL have parameter TID_WIDTH_P, default 2, hardware thread id width.
REQ-005 SHALL have one clock and an asynchronous, active-low reset.
REQ-006 SHALL have ports:
- clk_i  in  1  clock.
- rst_ni  in  1  async active-low reset.
- dec_valid_i / dec_ready_o  in/out  1  decode handshake.
- dec_tid_i  in  TID  thread id.
- dec_rs0_addr_i, dec_rs1_addr_i  in  REG_ADDR  source indices.
- dec_rs0_used_i, dec_rs1_used_i  in  1  operand is read.
- dec_src0_sel_i  in  xrv_exe_src0_sel_e  passed through.
- dec_src1_sel_i  in  xrv_exe_src1_sel_e  passed through.
- dec_imm0_i, dec_imm1_i  in  DATA  immediates.
- dec_pc_i  in  PC  instruction PC.
- rf_rd_en_o  out  1  register-file read strobe.
- rf_rd_tid_o  out  TID  read thread.
- rf_rs0_addr_o, rf_rs1_addr_o  out  REG_ADDR  read indices.
- rf_rs0_data_i, rf_rs1_data_i  in  DATA  read data, valid one cycle after rf_rd_en_o.
- wb_valid_i  in  1  writeback strobe.
- wb_tid_i  in  TID  writeback thread.
- wb_rd_addr_i  in  REG_ADDR  writeback index.
- wb_data_i  in  DATA  writeback value.
- flush_i  in  1  kill request.
- flush_tid_i  in  TID  thread to kill.
- exe_valid_o / exe_ready_i  out/in  1  execute handshake.
- exe_tid_o, exe_src0_sel_o, exe_src1_sel_o, exe_rs0_data_o, exe_rs1_data_o, exe_imm0_o, exe_imm1_o, exe_pc_o  out  held instruction fields; these feed the execute source mux.

Function
REQ-007 SHALL implement the FSM IDLE -> READ -> VALID.
REQ-008 dec_ready_o SHALL be 1 in IDLE, or in VALID when exe_ready_i=1; it SHALL be 0 in READ and whenever flush_i=1.
REQ-009 An accept (dec_valid_i & dec_ready_o) SHALL:
- move to READ;
- register all dec_* fields;
- drive rf_rd_en_o=1 with rf_rd_tid_o=dec_tid_i and the rf addresses equal to dec addresses, combinationally in the same cycle.
REQ-010 rf_rd_en_o SHALL be 0 in every non-accept cycle.
REQ-011 READ SHALL last exactly one cycle: capture operands, go to VALID.
REQ-012 Operand resolution in READ, per operand, highest priority first:
- addr==0 or used==0 -> 0;
- wb hit in this cycle -> wb_data_i;
- wb hit recorded in the accept cycle -> recorded data;
- otherwise rf data.
REQ-013 A wb hit SHALL require wb_valid_i, wb_tid_i==held tid, wb_rd_addr_i==operand addr, and addr!=0.
REQ-014 In VALID, a wb hit SHALL overwrite the matching held operand, visible the next cycle.
REQ-015 exe_valid_o SHALL be 1 exactly in VALID, with all exe_* outputs stable until the handshake completes.
REQ-016 On exe handshake: an accept in the same cycle goes to READ, otherwise to IDLE.
REQ-017 Minimum latency SHALL be accept at cycle N -> exe_valid_o at N+2; peak throughput SHALL be one instruction per 2 cycles.
REQ-018 flush_i with flush_tid_i==held tid in READ or VALID SHALL return the FSM to IDLE next cycle with exe_valid_o=0; the held instruction is dropped with no exe handshake.
REQ-019 flush_i with a non-matching tid SHALL leave the held instruction unaffected.
REQ-020 flush_i SHALL take priority over a same-cycle exe handshake.
REQ-021 A flush in IDLE SHALL have no effect beyond REQ-008.

Reset
REQ-022 While rst_ni=0, regardless of clk_i:
- FSM SHALL be IDLE;
- exe_valid_o=0;
- all held fields and operands SHALL be 0;
- recorded bypass flags SHALL be cleared.
REQ-023 Reset mid-operation SHALL discard any in-flight instruction; dec_ready_o=1 after reset deasserts.

Verification
REQ-024 Accept tid1, rs0=3 (RF=0x11), rs1=4 (RF=0x22) with exe_ready_i=1 -> exe_valid_o at +2 with rs0=0x11, rs1=0x22; next accept possible in the handshake cycle.
REQ-025 rs0=5, RF=0xAA, wb tid-match rd=5 data=0xBB in the READ cycle -> exe_rs0_data_o=0xBB; the same wb with a different tid -> 0xAA.
REQ-026 rs1=0 with wb rd=0 data=0xFF -> exe_rs1_data_o=0; rs0 with used=0 -> 0.
REQ-027 Hold VALID with exe_ready_i=0 for 3 cycles; wb matching rs1 with data=0x77 in cycle 2 -> exe_rs1_data_o=0x77 from cycle 3, exe_valid_o held, dec_ready_o=0.
REQ-028 flush_i with matching tid while in VALID and exe_ready_i=1 -> no handshake, IDLE next cycle, exe_valid_o=0; non-matching tid -> normal handshake.
REQ-029 Assert rst_ni=0 while in READ -> exe_valid_o=0 immediately; after release, the first accept produces correct operands at +2.

Source files
------------

// File: rtl/mrv1_operand_stage.sv
// Operand stage: accepts a decoded instruction, reads the register file, resolves writeback bypass, holds operands for execute.
// Latency 2 cycles accept->exe_valid_o; backpressure via exe_ready_i stalls in VALID and deasserts dec_ready_o.
module mrv1_operand_stage #(
   parameter int PC_WIDTH_P       = 32,
   parameter int DATA_WIDTH_P     = 32,
   parameter int REG_ADDR_WIDTH_P = 5,
   parameter int TID_WIDTH_P      = 2
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        dec_valid_i,
   output logic                        dec_ready_o,
   input  logic [TID_WIDTH_P-1:0]      dec_tid_i,
   input  logic [REG_ADDR_WIDTH_P-1:0] dec_rs0_addr_i,
   input  logic [REG_ADDR_WIDTH_P-1:0] dec_rs1_addr_i,
   input  logic                        dec_rs0_used_i,
   input  logic                        dec_rs1_used_i,
   input  logic [1:0]                  dec_src0_sel_i,
   input  logic [1:0]                  dec_src1_sel_i,
   input  logic [DATA_WIDTH_P-1:0]     dec_imm0_i,
   input  logic [DATA_WIDTH_P-1:0]     dec_imm1_i,
   input  logic [PC_WIDTH_P-1:0]       dec_pc_i,
   output logic                        rf_rd_en_o,
   output logic [TID_WIDTH_P-1:0]      rf_rd_tid_o,
   output logic [REG_ADDR_WIDTH_P-1:0] rf_rs0_addr_o,
   output logic [REG_ADDR_WIDTH_P-1:0] rf_rs1_addr_o,
   input  logic [DATA_WIDTH_P-1:0]     rf_rs0_data_i,
   input  logic [DATA_WIDTH_P-1:0]     rf_rs1_data_i,
   input  logic                        wb_valid_i,
   input  logic [TID_WIDTH_P-1:0]      wb_tid_i,
   input  logic [REG_ADDR_WIDTH_P-1:0] wb_rd_addr_i,
   input  logic [DATA_WIDTH_P-1:0]     wb_data_i,
   input  logic                        flush_i,
   input  logic [TID_WIDTH_P-1:0]      flush_tid_i,
   output logic                        exe_valid_o,
   input  logic                        exe_ready_i,
   output logic [TID_WIDTH_P-1:0]      exe_tid_o,
   output logic [1:0]                  exe_src0_sel_o,
   output logic [1:0]                  exe_src1_sel_o,
   output logic [DATA_WIDTH_P-1:0]     exe_rs0_data_o,
   output logic [DATA_WIDTH_P-1:0]     exe_rs1_data_o,
   output logic [DATA_WIDTH_P-1:0]     exe_imm0_o,
   output logic [DATA_WIDTH_P-1:0]     exe_imm1_o,
   output logic [PC_WIDTH_P-1:0]       exe_pc_o
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_READ = 2'd1, ST_VALID = 2'd2} state_e;

   state_e                        r_state, w_state_nxt;
   logic                          w_accept, w_flush_hit;
   logic                          w_wb_hit0, w_wb_hit1, w_acc_hit0, w_acc_hit1;
   logic [DATA_WIDTH_P-1:0]       w_op0, w_op1;

   logic [TID_WIDTH_P-1:0]        r_tid;
   logic [REG_ADDR_WIDTH_P-1:0]   r_rs0_addr, r_rs1_addr;
   logic                          r_rs0_used, r_rs1_used;
   logic [1:0]                    r_src0_sel, r_src1_sel;
   logic [DATA_WIDTH_P-1:0]       r_imm0, r_imm1, r_rs0_data, r_rs1_data;
   logic [PC_WIDTH_P-1:0]         r_pc;
   logic                          r_byp0_vld, r_byp1_vld;
   logic [DATA_WIDTH_P-1:0]       r_byp0_dat, r_byp1_dat;

   assign w_flush_hit = flush_i && (flush_tid_i == r_tid);

   // Hits against the held instruction; an unused operand must stay zero so it never takes a bypass.
   assign w_wb_hit0 = wb_valid_i && (wb_tid_i == r_tid) && (wb_rd_addr_i == r_rs0_addr)
                      && (r_rs0_addr != '0) && r_rs0_used;
   assign w_wb_hit1 = wb_valid_i && (wb_tid_i == r_tid) && (wb_rd_addr_i == r_rs1_addr)
                      && (r_rs1_addr != '0) && r_rs1_used;
   assign w_acc_hit0 = wb_valid_i && (wb_tid_i == dec_tid_i) && (wb_rd_addr_i == dec_rs0_addr_i)
                       && (dec_rs0_addr_i != '0);
   assign w_acc_hit1 = wb_valid_i && (wb_tid_i == dec_tid_i) && (wb_rd_addr_i == dec_rs1_addr_i)
                       && (dec_rs1_addr_i != '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      dec_ready_o = 1'b0;
      exe_valid_o = 1'b0;
      case (r_state)
         ST_IDLE: begin
            dec_ready_o = !flush_i;
            if (dec_valid_i && !flush_i) w_state_nxt = ST_READ;
         end
         ST_READ: begin
            w_state_nxt = w_flush_hit ? ST_IDLE : ST_VALID;
         end
         ST_VALID: begin
            exe_valid_o = 1'b1;
            dec_ready_o = exe_ready_i && !flush_i;
            if (w_flush_hit)      w_state_nxt = ST_IDLE;
            else if (exe_ready_i) w_state_nxt = (dec_valid_i && !flush_i) ? ST_READ : ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      w_accept   = dec_valid_i && dec_ready_o;
      rf_rd_en_o = w_accept;
   end

   assign rf_rd_tid_o   = dec_tid_i;
   assign rf_rs0_addr_o = dec_rs0_addr_i;
   assign rf_rs1_addr_o = dec_rs1_addr_i;

   always_comb begin
      w_op0 = rf_rs0_data_i;
      if (!r_rs0_used || r_rs0_addr == '0) w_op0 = '0;
      else if (w_wb_hit0)                  w_op0 = wb_data_i;
      else if (r_byp0_vld)                 w_op0 = r_byp0_dat;
      w_op1 = rf_rs1_data_i;
      if (!r_rs1_used || r_rs1_addr == '0) w_op1 = '0;
      else if (w_wb_hit1)                  w_op1 = wb_data_i;
      else if (r_byp1_vld)                 w_op1 = r_byp1_dat;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_tid      <= '0;
         r_rs0_addr <= '0;
         r_rs1_addr <= '0;
         r_rs0_used <= 1'b0;
         r_rs1_used <= 1'b0;
         r_src0_sel <= '0;
         r_src1_sel <= '0;
         r_imm0     <= '0;
         r_imm1     <= '0;
         r_pc       <= '0;
         r_rs0_data <= '0;
         r_rs1_data <= '0;
         r_byp0_vld <= 1'b0;
         r_byp1_vld <= 1'b0;
         r_byp0_dat <= '0;
         r_byp1_dat <= '0;
      end else if (w_accept) begin
         r_tid      <= dec_tid_i;
         r_rs0_addr <= dec_rs0_addr_i;
         r_rs1_addr <= dec_rs1_addr_i;
         r_rs0_used <= dec_rs0_used_i;
         r_rs1_used <= dec_rs1_used_i;
         r_src0_sel <= dec_src0_sel_i;
         r_src1_sel <= dec_src1_sel_i;
         r_imm0     <= dec_imm0_i;
         r_imm1     <= dec_imm1_i;
         r_pc       <= dec_pc_i;
         // The RF read launched this cycle cannot see a same-cycle writeback, so remember it.
         r_byp0_vld <= w_acc_hit0;
         r_byp1_vld <= w_acc_hit1;
         r_byp0_dat <= wb_data_i;
         r_byp1_dat <= wb_data_i;
      end else if (r_state == ST_READ) begin
         r_rs0_data <= w_op0;
         r_rs1_data <= w_op1;
      end else if (r_state == ST_VALID) begin
         if (w_wb_hit0) r_rs0_data <= wb_data_i;
         if (w_wb_hit1) r_rs1_data <= wb_data_i;
      end
   end

   assign exe_tid_o      = r_tid;
   assign exe_src0_sel_o = r_src0_sel;
   assign exe_src1_sel_o = r_src1_sel;
   assign exe_rs0_data_o = r_rs0_data;
   assign exe_rs1_data_o = r_rs1_data;
   assign exe_imm0_o     = r_imm0;
   assign exe_imm1_o     = r_imm1;
   assign exe_pc_o       = r_pc;

endmodule

// File: tb/tb_mrv1_operand_stage.sv
// Bench for mrv1_operand_stage: directed scenarios plus random traffic against an architectural register-file model.
// Expected operands are the current architectural register values; the bench also plays the register file.
module tb_mrv1_operand_stage;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        dec_valid_i = 1'b0, dec_ready_o;
   logic [1:0]  dec_tid_i = '0;
   logic [4:0]  dec_rs0_addr_i = '0, dec_rs1_addr_i = '0;
   logic        dec_rs0_used_i = 1'b0, dec_rs1_used_i = 1'b0;
   logic [1:0]  dec_src0_sel_i = '0, dec_src1_sel_i = '0;
   logic [31:0] dec_imm0_i = '0, dec_imm1_i = '0, dec_pc_i = '0;
   logic        rf_rd_en_o;
   logic [1:0]  rf_rd_tid_o;
   logic [4:0]  rf_rs0_addr_o, rf_rs1_addr_o;
   logic [31:0] rf_rs0_data_i = '0, rf_rs1_data_i = '0;
   logic        wb_valid_i = 1'b0;
   logic [1:0]  wb_tid_i = '0;
   logic [4:0]  wb_rd_addr_i = '0;
   logic [31:0] wb_data_i = '0;
   logic        flush_i = 1'b0;
   logic [1:0]  flush_tid_i = '0;
   logic        exe_valid_o, exe_ready_i = 1'b1;
   logic [1:0]  exe_tid_o, exe_src0_sel_o, exe_src1_sel_o;
   logic [31:0] exe_rs0_data_o, exe_rs1_data_o, exe_imm0_o, exe_imm1_o, exe_pc_o;

   mrv1_operand_stage dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o), .dec_tid_i(dec_tid_i),
      .dec_rs0_addr_i(dec_rs0_addr_i), .dec_rs1_addr_i(dec_rs1_addr_i),
      .dec_rs0_used_i(dec_rs0_used_i), .dec_rs1_used_i(dec_rs1_used_i),
      .dec_src0_sel_i(dec_src0_sel_i), .dec_src1_sel_i(dec_src1_sel_i),
      .dec_imm0_i(dec_imm0_i), .dec_imm1_i(dec_imm1_i), .dec_pc_i(dec_pc_i),
      .rf_rd_en_o(rf_rd_en_o), .rf_rd_tid_o(rf_rd_tid_o),
      .rf_rs0_addr_o(rf_rs0_addr_o), .rf_rs1_addr_o(rf_rs1_addr_o),
      .rf_rs0_data_i(rf_rs0_data_i), .rf_rs1_data_i(rf_rs1_data_i),
      .wb_valid_i(wb_valid_i), .wb_tid_i(wb_tid_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_data_i(wb_data_i),
      .flush_i(flush_i), .flush_tid_i(flush_tid_i),
      .exe_valid_o(exe_valid_o), .exe_ready_i(exe_ready_i),
      .exe_tid_o(exe_tid_o), .exe_src0_sel_o(exe_src0_sel_o), .exe_src1_sel_o(exe_src1_sel_o),
      .exe_rs0_data_o(exe_rs0_data_o), .exe_rs1_data_o(exe_rs1_data_o),
      .exe_imm0_o(exe_imm0_o), .exe_imm1_o(exe_imm1_o), .exe_pc_o(exe_pc_o)
   );

   always #5 clk_i = ~clk_i;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Architectural register state and the instruction the stage should be holding.
   logic [31:0] mem [4][32];
   bit          m_have = 0, m_valid = 0, rd_pend = 0;
   logic [1:0]  m_tid, m_s0, m_s1;
   logic [4:0]  m_a0, m_a1;
   bit          m_u0, m_u1;
   logic [31:0] m_imm0, m_imm1, m_pc, rd0, rd1;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] arch_op(input bit used, input logic [4:0] a);
      return (used && a != 5'd0) ? mem[m_tid][a] : 32'd0;
   endfunction

   task automatic check_outputs();
      chk("exe_valid", exe_valid_o, m_valid);
      if (m_valid) begin
         chk("exe_tid", exe_tid_o, m_tid);
         chk("exe_pc", exe_pc_o, m_pc);
         chk("exe_imm0", exe_imm0_o, m_imm0);
         chk("exe_imm1", exe_imm1_o, m_imm1);
         chk("exe_sel0", exe_src0_sel_o, m_s0);
         chk("exe_sel1", exe_src1_sel_o, m_s1);
         chk("exe_rs0", exe_rs0_data_o, arch_op(m_u0, m_a0));
         chk("exe_rs1", exe_rs1_data_o, arch_op(m_u1, m_a1));
      end
   endtask

   // Call at a negedge with the cycle's inputs driven; returns at the next negedge.
   task automatic cycle();
      bit exp_rdy, acc, fl, hs;
      rf_rs0_data_i = rd_pend ? rd0 : $urandom;
      rf_rs1_data_i = rd_pend ? rd1 : $urandom;
      #1;
      exp_rdy = !flush_i && (!m_have || (m_valid && exe_ready_i));
      chk("dec_ready", dec_ready_o, exp_rdy);
      acc = dec_valid_i && exp_rdy;
      chk("rf_rd_en", rf_rd_en_o, acc);
      if (acc) begin
         chk("rf_tid", rf_rd_tid_o, dec_tid_i);
         chk("rf_a0", rf_rs0_addr_o, dec_rs0_addr_i);
         chk("rf_a1", rf_rs1_addr_o, dec_rs1_addr_i);
      end
      fl = flush_i && m_have && (flush_tid_i == m_tid);
      hs = m_valid && exe_ready_i && !fl;
      rd_pend = acc;
      if (acc) begin
         rd0 = mem[dec_tid_i][dec_rs0_addr_i];
         rd1 = mem[dec_tid_i][dec_rs1_addr_i];
         m_have = 1; m_valid = 0;
         m_tid = dec_tid_i; m_a0 = dec_rs0_addr_i; m_a1 = dec_rs1_addr_i;
         m_u0 = dec_rs0_used_i; m_u1 = dec_rs1_used_i;
         m_s0 = dec_src0_sel_i; m_s1 = dec_src1_sel_i;
         m_imm0 = dec_imm0_i; m_imm1 = dec_imm1_i; m_pc = dec_pc_i;
      end else if (fl || hs) begin
         m_have = 0; m_valid = 0;
      end else if (m_have) begin
         m_valid = 1;
      end
      if (wb_valid_i) mem[wb_tid_i][wb_rd_addr_i] = wb_data_i;
      @(posedge clk_i);
      @(negedge clk_i);
      check_outputs();
   endtask

   task automatic quiet();
      dec_valid_i = 0; wb_valid_i = 0; flush_i = 0; exe_ready_i = 1;
   endtask

   task automatic issue(input logic [1:0] tid, input logic [4:0] a0, input logic [4:0] a1,
                        input bit u0, input bit u1);
      dec_valid_i = 1; dec_tid_i = tid;
      dec_rs0_addr_i = a0; dec_rs1_addr_i = a1; dec_rs0_used_i = u0; dec_rs1_used_i = u1;
      dec_src0_sel_i = 2'($urandom); dec_src1_sel_i = 2'($urandom);
      dec_imm0_i = $urandom; dec_imm1_i = $urandom; dec_pc_i = $urandom;
   endtask

   initial begin
      for (int t = 0; t < 4; t++)
         for (int r = 0; r < 32; r++) mem[t][r] = $urandom;

      // Reset state
      #1;
      chk("rst_exe_valid", exe_valid_o, 0);
      chk("rst_dec_ready", dec_ready_o, 1);
      chk("rst_rs0", exe_rs0_data_o, 0);
      chk("rst_pc", exe_pc_o, 0);
      @(negedge clk_i); @(negedge clk_i);
      rst_ni = 1;
      @(negedge clk_i);

      // Basic read, back-to-back accept in the handshake cycle
      mem[1][3] = 32'h11; mem[1][4] = 32'h22;
      quiet(); issue(2'd1, 5'd3, 5'd4, 1, 1); cycle();
      quiet(); cycle();
      chk("b2b_valid", exe_valid_o, 1);
      chk("b2b_rs0", exe_rs0_data_o, 32'h11);
      chk("b2b_rs1", exe_rs1_data_o, 32'h22);
      issue(2'd1, 5'd4, 5'd3, 1, 1); cycle();
      quiet(); cycle();
      chk("b2b2_rs0", exe_rs0_data_o, 32'h22);
      chk("b2b2_rs1", exe_rs1_data_o, 32'h11);
      cycle();

      // Writeback in the READ cycle: matching tid bypasses, other tid does not
      mem[0][5] = 32'hAA;
      issue(2'd0, 5'd5, 5'd1, 1, 0); cycle();
      quiet(); wb_valid_i = 1; wb_tid_i = 2'd0; wb_rd_addr_i = 5'd5; wb_data_i = 32'hBB; cycle();
      quiet(); chk("wb_read_hit", exe_rs0_data_o, 32'hBB); cycle();
      mem[0][5] = 32'hAA;
      issue(2'd0, 5'd5, 5'd1, 1, 0); cycle();
      quiet(); wb_valid_i = 1; wb_tid_i = 2'd2; wb_rd_addr_i = 5'd5; wb_data_i = 32'hBB; cycle();
      quiet(); chk("wb_read_miss", exe_rs0_data_o, 32'hAA); cycle();

      // Register zero and unused operand
      issue(2'd0, 5'd6, 5'd0, 0, 1);
      wb_valid_i = 1; wb_tid_i = 2'd0; wb_rd_addr_i = 5'd0; wb_data_i = 32'hFF; cycle();
      quiet(); wb_valid_i = 1; wb_tid_i = 2'd0; wb_rd_addr_i = 5'd0; wb_data_i = 32'hFF; cycle();
      quiet(); chk("x0_rs1", exe_rs1_data_o, 0); chk("unused_rs0", exe_rs0_data_o, 0); cycle();

      // Stall in VALID with a writeback to rs1
      mem[3][7] = 32'h33;
      issue(2'd3, 5'd2, 5'd7, 1, 1); exe_ready_i = 0; cycle();
      dec_valid_i = 0; cycle();
      dec_valid_i = 1; chk("stall_rs1_c1", exe_rs1_data_o, 32'h33); cycle();
      wb_valid_i = 1; wb_tid_i = 2'd3; wb_rd_addr_i = 5'd7; wb_data_i = 32'h77; cycle();
      wb_valid_i = 0;
      chk("stall_rs1_c3", exe_rs1_data_o, 32'h77);
      chk("stall_valid", exe_valid_o, 1);
      #1 chk("stall_dec_ready", dec_ready_o, 0);
      quiet(); cycle();

      // Flush in VALID: matching tid wins over exe_ready_i, other tid leaves it alone
      issue(2'd2, 5'd1, 5'd2, 1, 1); exe_ready_i = 0; cycle();
      dec_valid_i = 0; cycle();
      flush_i = 1; flush_tid_i = 2'd1; cycle();
      chk("flush_miss_valid", exe_valid_o, 1);
      flush_tid_i = 2'd2; exe_ready_i = 1; dec_valid_i = 1; cycle();
      chk("flush_hit_valid", exe_valid_o, 0);
      quiet(); cycle(); cycle();

      // Reset while in READ
      issue(2'd1, 5'd3, 5'd4, 1, 1); cycle();
      quiet(); rst_ni = 0; #1;
      chk("midrst_valid", exe_valid_o, 0);
      chk("midrst_rs0", exe_rs0_data_o, 0);
      chk("midrst_pc", exe_pc_o, 0);
      m_have = 0; m_valid = 0; rd_pend = 0;
      @(negedge clk_i); @(negedge clk_i);
      rst_ni = 1;
      @(negedge clk_i);
      mem[1][3] = 32'h5A5A; mem[1][4] = 32'hA5A5;
      issue(2'd1, 5'd3, 5'd4, 1, 1); cycle();
      quiet(); cycle();
      chk("postrst_valid", exe_valid_o, 1);
      chk("postrst_rs0", exe_rs0_data_o, 32'h5A5A);
      chk("postrst_rs1", exe_rs1_data_o, 32'hA5A5);
      cycle();

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         dec_valid_i = ($urandom_range(9) < 7);
         issue(2'($urandom), 5'($urandom_range(7)), 5'($urandom_range(7)),
               $urandom_range(9) < 8, $urandom_range(9) < 8);
         dec_valid_i = ($urandom_range(9) < 7);
         exe_ready_i = ($urandom_range(9) < 6);
         wb_valid_i = $urandom_range(1);
         wb_tid_i = $urandom_range(1) ? m_tid : 2'($urandom);
         case ($urandom_range(2))
            0:       wb_rd_addr_i = m_a0;
            1:       wb_rd_addr_i = m_a1;
            default: wb_rd_addr_i = 5'($urandom_range(7));
         endcase
         wb_data_i = $urandom;
         flush_i = ($urandom_range(9) == 0);
         flush_tid_i = $urandom_range(1) ? m_tid : 2'($urandom);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
